t08_lcd_bus_ctrl: RTL and testbench

Parametrised 8080-style parallel LCD bus master, the next-generation command/parameter engine for the display path.
- Accepts one transaction per valid/ready request: a command byte, then a programmable-length stream of write data or read data.
- Length ranges from 0 to 2^LEN_W-1 beats, so full-frame MEMWR bursts need no per-command parameter table.
- Sits between the graphics/command sequencer and the panel pins; generates csx/dcx/wrx/rdx with configurable strobe timing and bus tri-state control.

---
 rtl/t08_lcd_bus_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_t08_lcd_bus_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/t08_lcd_bus_ctrl.sv
// 8080-style parallel LCD bus master: one command byte per request,
// followed by a programmable-length stream of write or read beats.
module t08_lcd_bus_ctrl #(
  parameter int BUS_W      = 8,
  parameter int LEN_W      = 18,
  parameter int WR_LOW     = 1,
  parameter int WR_HIGH    = 1,
  parameter int RD_LOW     = 4,
  parameter int RD_HIGH    = 2,
  parameter int DUMMY_READ = 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_cmd,
  input  logic [LEN_W-1:0] req_len,
  input  logic             req_read,
  input  logic [BUS_W-1:0] wdata,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  output logic [BUS_W-1:0] rdata,
  output logic             rdata_valid,
  input  logic [BUS_W-1:0] bus_in,
  output logic [BUS_W-1:0] bus_out,
  output logic             bus_oe,
  output logic             csx,
  output logic             dcx,
  output logic             wrx,
  output logic             rdx,
  output logic             busy,
  output logic             done
);

  localparam int TW = 8;
  localparam logic [TW-1:0] WL_T = TW'(WR_LOW - 1);
  localparam logic [TW-1:0] WH_T = TW'(WR_HIGH - 1);
  localparam logic [TW-1:0] RL_T = TW'(RD_LOW - 1);
  localparam logic [TW-1:0] RH_T = TW'(RD_HIGH - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD_LO, S_CMD_HI, S_WAIT,
    S_WR_LO, S_WR_HI, S_RD_LO, S_RD_HI, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             rd_q, rd_d;
  logic             dmy_q, dmy_d;
  logic             accept, wr_take, rd_smp;

  logic             csx_q, csx_d;
  logic             dcx_q, dcx_d;
  logic             wrx_q, wrx_d;
  logic             rdx_q, rdx_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rrdy_q, rrdy_d;
  logic             wrdy_q, wrdy_d;
  logic             rdv_q, rdv_d;
  logic [BUS_W-1:0] bout_q, bout_d;
  logic [BUS_W-1:0] rdat_q, rdat_d;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      rd_q    <= 1'b0;
      dmy_q   <= 1'b0;
      csx_q   <= 1'b1;
      dcx_q   <= 1'b1;
      wrx_q   <= 1'b1;
      rdx_q   <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rrdy_q  <= 1'b1;
      wrdy_q  <= 1'b0;
      rdv_q   <= 1'b0;
      bout_q  <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      rd_q    <= rd_d;
      dmy_q   <= dmy_d;
      csx_q   <= csx_d;
      dcx_q   <= dcx_d;
      wrx_q   <= wrx_d;
      rdx_q   <= rdx_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rrdy_q  <= rrdy_d;
      wrdy_q  <= wrdy_d;
      rdv_q   <= rdv_d;
      bout_q  <= bout_d;
      rdat_q  <= rdat_d;
    end
  end

  // tmr_q counts cycles spent in the current strobe phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q + TW'(1);
    rd_d    = rd_q;
    dmy_d   = dmy_q;
    accept  = 1'b0;
    wr_take = 1'b0;
    rd_smp  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = S_CMD_LO;
          cnt_d   = req_len;
          rd_d    = req_read;
          dmy_d   = (DUMMY_READ != 0);
        end
      end
      S_CMD_LO: begin
        if (tmr_q == WL_T) begin
          tmr_d   = '0;
          state_d = S_CMD_HI;
        end
      end
      S_CMD_HI: begin
        if (tmr_q == WH_T) begin
          tmr_d = '0;
          if (cnt_q == '0)  state_d = S_DONE;
          else if (rd_q)    state_d = S_RD_LO;
          else              state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tmr_d = '0;
        if (wdata_valid) begin
          wr_take = 1'b1;
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = S_WR_LO;
        end
      end
      S_WR_LO: begin
        if (tmr_q == WL_T) begin
          tmr_d   = '0;
          state_d = S_WR_HI;
        end
      end
      S_WR_HI: begin
        if (tmr_q == WH_T) begin
          tmr_d   = '0;
          state_d = (cnt_q == '0) ? S_DONE : S_WAIT;
        end
      end
      S_RD_LO: begin
        if (tmr_q == RL_T) begin
          tmr_d   = '0;
          rd_smp  = 1'b1;
          state_d = S_RD_HI;
          // the dummy beat is not part of the requested length
          if (dmy_q) dmy_d = 1'b0;
          else       cnt_d = cnt_q - LEN_W'(1);
        end
      end
      S_RD_HI: begin
        if (tmr_q == RH_T) begin
          tmr_d   = '0;
          state_d = (cnt_q == '0) ? S_DONE : S_RD_LO;
        end
      end
      S_DONE: begin
        tmr_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        tmr_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    csx_d  = (state_d == S_IDLE) || (state_d == S_DONE);
    dcx_d  = !((state_d == S_CMD_LO) || (state_d == S_CMD_HI));
    wrx_d  = !((state_d == S_CMD_LO) || (state_d == S_WR_LO));
    rdx_d  = (state_d != S_RD_LO);
    oe_d   = state_d inside {S_CMD_LO, S_CMD_HI, S_WAIT,
                             S_WR_LO, S_WR_HI};
    busy_d = !csx_d;
    done_d = (state_d == S_DONE);
    rrdy_d = (state_d == S_IDLE);
    wrdy_d = (state_d == S_WAIT);
    bout_d = bout_q;
    if (accept)       bout_d = BUS_W'(req_cmd);
    else if (wr_take) bout_d = wdata;
    rdat_d = rdat_q;
    rdv_d  = 1'b0;
    if (rd_smp && !dmy_q) begin
      rdat_d = bus_in;
      rdv_d  = 1'b1;
    end
  end

  assign req_ready   = rrdy_q;
  assign wdata_ready = wrdy_q;
  assign rdata       = rdat_q;
  assign rdata_valid = rdv_q;
  assign bus_out     = bout_q;
  assign bus_oe      = oe_q;
  assign csx         = csx_q;
  assign dcx         = dcx_q;
  assign wrx         = wrx_q;
  assign rdx         = rdx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_t08_lcd_bus_ctrl.sv
// Bench for t08_lcd_bus_ctrl: an 8-bit default instance and a 16-bit,
// 3-bit-length instance driven from one vector table.
module tb_t08_lcd_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst;
  logic        sel;
  logic        req_valid;
  logic [7:0]  req_cmd;
  logic [17:0] req_len;
  logic        req_read;
  logic [15:0] wdata;
  logic        wvalid;
  logic [15:0] bus_in;

  logic        a_rrdy, a_wrdy, a_rdv, a_oe;
  logic        a_csx, a_dcx, a_wrx, a_rdx, a_busy, a_done;
  logic [7:0]  a_rdata, a_bout;
  logic        b_rrdy, b_wrdy, b_rdv, b_oe;
  logic        b_csx, b_dcx, b_wrx, b_rdx, b_busy, b_done;
  logic [15:0] b_rdata, b_bout;

  logic        m_rrdy, m_wrdy, m_rdv, m_oe;
  logic        m_csx, m_dcx, m_wrx, m_rdx, m_busy, m_done;
  logic [15:0] m_rdata, m_bout;

  t08_lcd_bus_ctrl #(
    .BUS_W(8), .LEN_W(18), .WR_LOW(1), .WR_HIGH(1),
    .RD_LOW(4), .RD_HIGH(2), .DUMMY_READ(1)
  ) u_a (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid & ~sel), .req_ready(a_rrdy),
    .req_cmd(req_cmd), .req_len(req_len), .req_read(req_read),
    .wdata(wdata[7:0]), .wdata_valid(wvalid & ~sel),
    .wdata_ready(a_wrdy), .rdata(a_rdata), .rdata_valid(a_rdv),
    .bus_in(bus_in[7:0]), .bus_out(a_bout), .bus_oe(a_oe),
    .csx(a_csx), .dcx(a_dcx), .wrx(a_wrx), .rdx(a_rdx),
    .busy(a_busy), .done(a_done)
  );

  t08_lcd_bus_ctrl #(
    .BUS_W(16), .LEN_W(3), .WR_LOW(2), .WR_HIGH(1),
    .RD_LOW(4), .RD_HIGH(2), .DUMMY_READ(0)
  ) u_b (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid & sel), .req_ready(b_rrdy),
    .req_cmd(req_cmd), .req_len(req_len[2:0]), .req_read(req_read),
    .wdata(wdata), .wdata_valid(wvalid & sel),
    .wdata_ready(b_wrdy), .rdata(b_rdata), .rdata_valid(b_rdv),
    .bus_in(bus_in), .bus_out(b_bout), .bus_oe(b_oe),
    .csx(b_csx), .dcx(b_dcx), .wrx(b_wrx), .rdx(b_rdx),
    .busy(b_busy), .done(b_done)
  );

  assign m_rrdy  = sel ? b_rrdy  : a_rrdy;
  assign m_wrdy  = sel ? b_wrdy  : a_wrdy;
  assign m_rdv   = sel ? b_rdv   : a_rdv;
  assign m_oe    = sel ? b_oe    : a_oe;
  assign m_csx   = sel ? b_csx   : a_csx;
  assign m_dcx   = sel ? b_dcx   : a_dcx;
  assign m_wrx   = sel ? b_wrx   : a_wrx;
  assign m_rdx   = sel ? b_rdx   : a_rdx;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_rdata = sel ? b_rdata : {8'h00, a_rdata};
  assign m_bout  = sel ? b_bout  : {8'h00, a_bout};

  typedef struct {
    bit               sel;
    logic [7:0]       cmd;
    int               len;
    bit               rd;
    logic [7:0][15:0] wd;
    logic [7:0][15:0] bin;
    int               n_wr;
    int               n_rdp;
    int               n_rdv;
    logic [3:0][15:0] rdv;
    int               lat;
    bit               stall;
    int               rst_cyc;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit s, logic [7:0] c, int l, bit r,
                              int lt);
    vec_t v;
    v.sel = s; v.cmd = c; v.len = l; v.rd = r;
    v.wd = '0; v.bin = '0; v.rdv = '0;
    v.n_wr = r ? 1 : l + 1;
    v.n_rdp = 0; v.n_rdv = 0;
    v.lat = lt; v.stall = 1'b0; v.rst_cyc = 0;
    return v;
  endfunction

  // Cycle 1 is the cycle that begins at the accept edge.
  task automatic run(input vec_t v);
    int lat, nw, nrp, nrv, idx, stall_n, viol;
    bit hs, wp, rp;
    logic [16:0] cw [16];
    logic [15:0] cr [8];
    logic [16:0] ew;
    lat = -1; nw = 0; nrp = 0; nrv = 0; idx = 0;
    stall_n = 0; viol = 0; hs = 0; wp = 1; rp = 1;
    sel = v.sel;
    @(negedge clk);
    chk("idle_ready", m_rrdy, 1);
    req_valid = 1; req_cmd = v.cmd; req_len = 18'(v.len);
    req_read = v.rd; wdata = v.wd[0]; wvalid = !v.rd;
    @(posedge clk);
    #1;
    req_valid = 0; req_cmd = 8'hFF; req_len = '0; req_read = ~v.rd;
    for (int cyc = 1; cyc <= 300 && lat < 0; cyc++) begin
      @(negedge clk);
      if (hs) idx++;
      hs = 0;
      if (idx < 8) wdata = v.wd[idx];
      if (v.stall && idx == 2 && stall_n < 5) begin
        wvalid = 0;
        stall_n++;
        if (m_csx) viol++;
        if (stall_n == 5) begin
          chk("stall_wready", m_wrdy, 1);
          chk("stall_wrx", m_wrx, 1);
        end
      end else begin
        wvalid = !v.rd;
      end
      hs = wvalid && m_wrdy;
      if (!m_wrx && wp) begin
        if (nw < 16) cw[nw] = {m_dcx, m_bout};
        nw++;
        if (!m_oe || m_csx) viol++;
      end
      if (!m_rdx && rp) begin
        if (nrp < 8) bus_in = v.bin[nrp];
        nrp++;
      end
      if (!m_rdx && (m_oe || m_csx)) viol++;
      if (!m_rdx && !m_wrx) viol++;
      if (m_rdv) begin
        if (nrv < 8) cr[nrv] = m_rdata;
        nrv++;
      end
      wp = m_wrx;
      rp = m_rdx;
      if (v.rst_cyc == cyc) begin
        chk("pre_rst_wrx_low", m_wrx, 0);
        nrst = 0;
        @(negedge clk);
        chk("rst_csx", m_csx, 1);
        chk("rst_wrx", m_wrx, 1);
        chk("rst_busy", m_busy, 0);
        chk("rst_done", m_done, 0);
        chk("rst_oe", m_oe, 0);
        chk("rst_ready", m_rrdy, 1);
        nrst = 1;
        wvalid = 0;
        repeat (4) begin
          @(negedge clk);
          if (m_done || m_busy) viol++;
        end
        chk("rst_quiet", viol, 0);
        return;
      end
      if (m_done) begin
        lat = cyc;
        chk("done_csx", m_csx, 1);
        chk("done_busy", m_busy, 0);
        chk("done_oe", m_oe, 0);
        chk("done_dcx", m_dcx, 1);
      end
    end
    chk("latency", lat, v.lat);
    @(negedge clk);
    chk("ready_after_done", m_rrdy, 1);
    chk("done_one_cycle", m_done, 0);
    wvalid = 0;
    chk("wr_pulses", nw, v.n_wr);
    for (int i = 0; i < nw && i < v.n_wr && i < 16; i++) begin
      ew = (i == 0) ? {1'b0, 8'h00, v.cmd} : {1'b1, v.wd[i-1]};
      chk($sformatf("wr_beat%0d", i), cw[i], ew);
    end
    chk("rd_pulses", nrp, v.n_rdp);
    chk("rdata_count", nrv, v.n_rdv);
    for (int i = 0; i < nrv && i < v.n_rdv && i < 4; i++)
      chk($sformatf("rdata%0d", i), cr[i], v.rdv[i]);
    chk("strobe_rules", viol, 0);
  endtask

  vec_t tv [6];
  vec_t hv;

  initial begin
    nrst = 0; sel = 0; req_valid = 0; req_cmd = '0; req_len = '0;
    req_read = 0; wdata = '0; wvalid = 0; bus_in = '0;

    tv[0] = mk(0, 8'h01, 0, 0, 3);
    tv[1] = mk(0, 8'h2A, 4, 0, 15);
    tv[1].wd[0] = 16'h00; tv[1].wd[1] = 16'h00;
    tv[1].wd[2] = 16'h00; tv[1].wd[3] = 16'hEF;
    tv[2] = mk(0, 8'h09, 2, 1, 21);
    tv[2].bin[0] = 16'h5A; tv[2].bin[1] = 16'h3C;
    tv[2].bin[2] = 16'h7E;
    tv[2].n_rdp = 3; tv[2].n_rdv = 2;
    tv[2].rdv[0] = 16'h3C; tv[2].rdv[1] = 16'h7E;
    tv[3] = mk(1, 8'h2C, 2, 0, 12);
    tv[3].wd[0] = 16'hF800; tv[3].wd[1] = 16'h07E0;
    tv[4] = mk(1, 8'h2C, 7, 0, 32);
    tv[4].wd[0] = 16'hFFFF; tv[4].wd[1] = 16'h0001;
    tv[4].wd[2] = 16'h8000; tv[4].wd[3] = 16'hA5A5;
    tv[4].wd[4] = 16'h5A5A; tv[4].wd[5] = 16'h1234;
    tv[4].wd[6] = 16'hBEEF;
    tv[5] = mk(1, 8'h0A, 1, 1, 10);
    tv[5].bin[0] = 16'h1234;
    tv[5].n_rdp = 1; tv[5].n_rdv = 1; tv[5].rdv[0] = 16'h1234;

    repeat (3) @(negedge clk);
    chk("reset_csx", a_csx, 1);
    chk("reset_dcx", a_dcx, 1);
    chk("reset_wrx", a_wrx, 1);
    chk("reset_rdx", a_rdx, 1);
    chk("reset_bus", {a_oe, a_bout}, 0);
    chk("reset_busy_done", {a_busy, a_done}, 0);
    chk("reset_rdata", {a_rdv, a_rdata}, 0);
    chk("reset_wready", a_wrdy, 0);
    chk("reset_rready", a_rrdy, 1);
    chk("reset_b", {b_csx, b_wrx, b_rdx, b_oe, b_bout}, 20'hE0000);
    nrst = 1;

    for (int k = 0; k < 6; k++) run(tv[k]);

    hv = tv[1];
    hv.stall = 1'b1;
    hv.lat = 18;
    run(hv);

    hv = mk(0, 8'h2C, 4, 0, 0);
    hv.wd[0] = 16'h11; hv.wd[1] = 16'h22;
    hv.wd[2] = 16'h33; hv.wd[3] = 16'h44;
    hv.rst_cyc = 7;
    run(hv);
    run(tv[0]);
    run(tv[1]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
